// File: rtl/shifter_arb_pkg.sv
// shifter_arb_pkg: shared widths, response FSM states and the muxed operand bundle
package shifter_arb_pkg;
    localparam int DATA_W = 16;
    localparam int SHAMT_W = 4;

    typedef enum logic {ST_EMPTY, ST_FULL} state_t;

    typedef struct packed {
        logic left_right;
        logic [SHAMT_W-1:0] shamt;
        logic [DATA_W-1:0] src;
    } shift_op_t;
endpackage

// File: rtl/Shifter_Barrel.sv
// Shifter_Barrel: 16-bit logical barrel shifter, left_right=1 shifts left, zero fill
module Shifter_Barrel (
    input  logic [15:0] src,
    input  logic [3:0]  shamt,
    input  logic        left_right,
    output logic [15:0] result
);
    assign result = left_right ? src << shamt : src >> shamt;
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first set req at or above ptr, wrapping
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] grant,
    output logic [W-1:0] idx
);
    logic [W-1:0] j;

    // Walk from the farthest candidate back to ptr so the nearest request wins.
    always_comb begin
        grant = '0;
        idx = '0;
        j = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = W'((int'(ptr) + k) % N);
            if (req[j]) begin
                grant = '0;
                grant[j] = 1'b1;
                idx = j;
            end
        end
    end
endmodule

// File: rtl/shifter_rr_arbiter.sv
// shifter_rr_arbiter: round-robin sharing of one Shifter_Barrel with a registered tagged response
// Define SHIFTER_ARB_STATS_EN to add saturating per-requester grant counters on grant_cnt.
module shifter_rr_arbiter
    import shifter_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W = $clog2(NUM_REQ)
`ifdef SHIFTER_ARB_STATS_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ-1:0]         req_left_right,
    input  logic [NUM_REQ*SHAMT_W-1:0] req_shamt,
    input  logic [NUM_REQ*DATA_W-1:0]  req_src,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [ID_W-1:0]            rsp_id,
    output logic [DATA_W-1:0]          rsp_result
`ifdef SHIFTER_ARB_STATS_EN
    ,
    output logic [NUM_REQ*CNT_W-1:0]   grant_cnt
`endif
);
    state_t state;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] gidx;
    logic [NUM_REQ-1:0] gnt;
    logic [NUM_REQ-1:0] req_masked;
    logic can_accept;
    logic xfer;
    shift_op_t op;
    logic [DATA_W-1:0] shift_res;

    assign rsp_valid = state == ST_FULL;
    assign can_accept = !rsp_valid || rsp_ready;
    assign req_masked = can_accept ? req_valid : '0;
    assign req_ready = gnt;
    assign xfer = |gnt;

    rr_arbiter #(.N(NUM_REQ), .W(ID_W)) u_arb (
        .req   (req_masked),
        .ptr   (rr_ptr),
        .grant (gnt),
        .idx   (gidx)
    );

    always_comb op = '{
        left_right: req_left_right[gidx],
        shamt:      req_shamt[gidx*SHAMT_W +: SHAMT_W],
        src:        req_src[gidx*DATA_W +: DATA_W]
    };

    Shifter_Barrel u_shift (
        .src        (op.src),
        .shamt      (op.shamt),
        .left_right (op.left_right),
        .result     (shift_res)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_EMPTY;
            rr_ptr <= '0;
            rsp_id <= '0;
            rsp_result <= '0;
        end else if (xfer) begin
            state <= ST_FULL;
            rr_ptr <= (gidx == ID_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
            rsp_id <= gidx;
            rsp_result <= shift_res;
        end else if (rsp_ready) begin
            state <= ST_EMPTY;
        end
    end

`ifdef SHIFTER_ARB_STATS_EN
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rst)
                grant_cnt[i*CNT_W +: CNT_W] <= '0;
            else if (gnt[i] && grant_cnt[i*CNT_W +: CNT_W] != {CNT_W{1'b1}})
                grant_cnt[i*CNT_W +: CNT_W] <= grant_cnt[i*CNT_W +: CNT_W] + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_shifter_rr_arbiter.sv
// tb_shifter_rr_arbiter: directed scenarios plus a response scoreboard for shifter_rr_arbiter
module tb_shifter_rr_arbiter;
    localparam int NUM_REQ = 4;
    localparam int CNT_W = 4;

    logic clk = 0;
    logic rst = 1;
    logic [NUM_REQ-1:0] req_valid = '0;
    logic [NUM_REQ-1:0] req_ready;
    logic [NUM_REQ-1:0] req_left_right = '0;
    logic [NUM_REQ*4-1:0] req_shamt = '0;
    logic [NUM_REQ*16-1:0] req_src = '0;
    logic rsp_valid;
    logic rsp_ready = 0;
    logic [1:0] rsp_id;
    logic [15:0] rsp_result;
`ifdef SHIFTER_ARB_STATS_EN
    logic [NUM_REQ*CNT_W-1:0] grant_cnt;
`endif

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [1:0] id;
        logic [15:0] res;
    } exp_t;
    exp_t sb[$];
    bit m_full;
    bit found;
    int m_ptr;
    int g;
    int gsel;
    logic [NUM_REQ-1:0] exp_gnt;

    always #5 clk = ~clk;

    shifter_rr_arbiter #(
        .NUM_REQ(NUM_REQ)
`ifdef SHIFTER_ARB_STATS_EN
        , .CNT_W(CNT_W)
`endif
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_left_right (req_left_right),
        .req_shamt      (req_shamt),
        .req_src        (req_src),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_id         (rsp_id),
        .rsp_result     (rsp_result)
`ifdef SHIFTER_ARB_STATS_EN
        , .grant_cnt    (grant_cnt)
`endif
    );

    function automatic logic [15:0] shf(input logic lr, input logic [3:0] sh, input logic [15:0] s);
        return lr ? s << sh : s >> sh;
    endfunction

    task automatic set_req(input int i, input logic lr, input logic [3:0] sh, input logic [15:0] s);
        req_left_right[i] = lr;
        req_shamt[i*4 +: 4] = sh;
        req_src[i*16 +: 16] = s;
    endtask

    // Reference model: predicts grants and queues the response each transfer must produce.
    always @(negedge clk) begin
        if (rst) begin
            m_full = 0;
            m_ptr = 0;
            sb.delete();
        end else begin
            checks++;
            if (rsp_valid !== m_full) begin
                failures++;
                $display("FAIL sb_rsp_valid got=%0b exp=%0b t=%0t", rsp_valid, m_full, $time);
            end
            if (m_full) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL sb_underflow got=empty exp=entry t=%0t", $time);
                end else begin
                    if (rsp_id !== sb[0].id || rsp_result !== sb[0].res) begin
                        failures++;
                        $display("FAIL sb_rsp got=%0d/%h exp=%0d/%h t=%0t", rsp_id, rsp_result, sb[0].id, sb[0].res, $time);
                    end
                    if (rsp_ready) void'(sb.pop_front());
                end
            end
            exp_gnt = '0;
            found = 0;
            gsel = 0;
            if (!m_full || rsp_ready) begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    g = (m_ptr + k) % NUM_REQ;
                    if (!found && req_valid[g]) begin
                        found = 1;
                        gsel = g;
                    end
                end
            end
            if (found) exp_gnt[gsel] = 1'b1;
            checks++;
            if (req_ready !== exp_gnt) begin
                failures++;
                $display("FAIL sb_grant got=%b exp=%b t=%0t", req_ready, exp_gnt, $time);
            end
            if (found) begin
                sb.push_back('{2'(gsel), shf(req_left_right[gsel], req_shamt[gsel*4 +: 4], req_src[gsel*16 +: 16])});
                m_ptr = (gsel + 1) % NUM_REQ;
                m_full = 1;
            end else if (rsp_ready) begin
                m_full = 0;
            end
        end
    end

    task automatic test_reset;
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_result !== 16'h0 || req_ready !== 4'b0) begin
            failures++;
            $display("FAIL reset_state got=%b/%0d/%h/%b exp=0/0/0000/0000", rsp_valid, rsp_id, rsp_result, req_ready);
        end
        @(posedge clk); #1;
        rst = 0;
    endtask

    task automatic test_single;
        rsp_ready = 1;
        set_req(0, 1, 4, 16'h0001);
        req_valid = 4'b0001;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL single_grant got=%b exp=0001", req_ready);
        end
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_result !== 16'h0010) begin
            failures++;
            $display("FAIL single_rsp got=%b/%0d/%h exp=1/0/0010", rsp_valid, rsp_id, rsp_result);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_right;
        set_req(2, 0, 15, 16'h8000);
        req_valid = 4'b0100;
        @(negedge clk);
        @(posedge clk); #1;
        set_req(2, 0, 0, 16'hA5A5);
        @(negedge clk);
        checks++;
        if (rsp_id !== 2'd2 || rsp_result !== 16'h0001) begin
            failures++;
            $display("FAIL right_15 got=%0d/%h exp=2/0001", rsp_id, rsp_result);
        end
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_result !== 16'hA5A5) begin
            failures++;
            $display("FAIL shamt_zero got=%b/%0d/%h exp=1/2/a5a5", rsp_valid, rsp_id, rsp_result);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_round_robin;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, i[0], 4'(i + 1), 16'h0180 + 16'(i));
        req_valid = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            if (k == 5) req_valid = '0;
            @(negedge clk);
            if (k < 5) begin
                checks++;
                if (req_ready !== 4'(1 << (k % 4))) begin
                    failures++;
                    $display("FAIL rr_grant_%0d got=%b exp=%b", k, req_ready, 4'(1 << (k % 4)));
                end
            end
            if (k > 0) begin
                checks++;
                if (rsp_valid !== 1'b1 || rsp_id !== 2'((k - 1) % 4)) begin
                    failures++;
                    $display("FAIL rr_rsp_%0d got=%b/%0d exp=1/%0d", k, rsp_valid, rsp_id, (k - 1) % 4);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure;
        rsp_ready = 1;
        set_req(1, 1, 4, 16'h000F);
        req_valid = 4'b0010;
        @(negedge clk);
        @(posedge clk); #1;
        set_req(3, 0, 2, 16'h1234);
        req_valid = 4'b1000;
        rsp_ready = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_result !== 16'h00F0 || rsp_id !== 2'd1 || req_ready !== 4'b0) begin
                failures++;
                $display("FAIL bp_hold_%0d got=%b/%h/%0d/%b exp=1/00f0/1/0000", c, rsp_valid, rsp_result, rsp_id, req_ready);
            end
            @(posedge clk); #1;
        end
        rsp_ready = 1;
        set_req(1, 1, 1, 16'h0001);
        req_valid = 4'b0010;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0010 || rsp_result !== 16'h00F0) begin
            failures++;
            $display("FAIL bp_drain got=%b/%h exp=0010/00f0", req_ready, rsp_result);
        end
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_result !== 16'h0002) begin
            failures++;
            $display("FAIL bp_reload got=%b/%0d/%h exp=1/1/0002", rsp_valid, rsp_id, rsp_result);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        rsp_ready = 0;
        set_req(2, 1, 3, 16'h0003);
        req_valid = 4'b0100;
        @(negedge clk);
        @(posedge clk); #1;
        req_valid = '0;
        rst = 1;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1) begin
            failures++;
            $display("FAIL mid_pre got=%b exp=1", rsp_valid);
        end
        @(posedge clk); #1;
        rst = 0;
        rsp_ready = 1;
        set_req(0, 1, 1, 16'h0101);
        set_req(3, 1, 1, 16'h0303);
        req_valid = 4'b1001;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || rsp_result !== 16'h0 || req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL mid_reset got=%b/%h/%b exp=0/0000/0001", rsp_valid, rsp_result, req_ready);
        end
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        @(posedge clk); #1;
    endtask

`ifdef SHIFTER_ARB_STATS_EN
    task automatic test_stats;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        rsp_ready = 1;
        req_valid = 4'b0001;
        repeat (5) @(posedge clk);
        #1;
        req_valid = 4'b1000;
        repeat (3) @(posedge clk);
        #1;
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (grant_cnt !== {4'd3, 4'd0, 4'd0, 4'd5}) begin
            failures++;
            $display("FAIL stats_count got=%h exp=3005", grant_cnt);
        end
        @(posedge clk); #1;
        req_valid = 4'b0001;
        repeat (12) @(posedge clk);
        #1;
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (grant_cnt !== {4'd3, 4'd0, 4'd0, 4'hF}) begin
            failures++;
            $display("FAIL stats_saturate got=%h exp=300f", grant_cnt);
        end
        @(posedge clk); #1;
    endtask
`endif

    task automatic test_drain;
        rsp_ready = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (sb.size() != 0 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL drain got=%0d/%b exp=0/0", sb.size(), rsp_valid);
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_right;
        test_round_robin;
        test_backpressure;
        test_reset_mid;
`ifdef SHIFTER_ARB_STATS_EN
        test_stats;
`endif
        test_drain;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
